// File: rtl/stage_id_pkg.sv
// stage_id_pkg
//   Shared TSC definitions for the decode stage: word size, register file
//   geometry, opcode and R-type function codes, the control bundle carried
//   to EX and its width (ID_CTRL_W), and immediate-extension helpers.
//   Decode logic uses these names and does not define its own copies.
package stage_id_pkg;

  localparam int WORD_SIZE = 16;
  localparam int NUM_REGS_DEFAULT = 4;
  localparam int REG_IDX_W = 2;
  localparam logic [REG_IDX_W-1:0] LINK_REG_DEFAULT = 2'd2;

  // Major opcodes, instr[15:12]
  localparam logic [3:0] OP_BNE   = 4'd0;
  localparam logic [3:0] OP_BEQ   = 4'd1;
  localparam logic [3:0] OP_BGZ   = 4'd2;
  localparam logic [3:0] OP_BLZ   = 4'd3;
  localparam logic [3:0] OP_ADI   = 4'd4;
  localparam logic [3:0] OP_ORI   = 4'd5;
  localparam logic [3:0] OP_LHI   = 4'd6;
  localparam logic [3:0] OP_LWD   = 4'd7;
  localparam logic [3:0] OP_SWD   = 4'd8;
  localparam logic [3:0] OP_JMP   = 4'd9;
  localparam logic [3:0] OP_JAL   = 4'd10;
  localparam logic [3:0] OP_RTYPE = 4'd15;

  // R-type function codes, instr[5:0]
  localparam logic [5:0] FUNC_ADD = 6'd0;
  localparam logic [5:0] FUNC_SUB = 6'd1;
  localparam logic [5:0] FUNC_AND = 6'd2;
  localparam logic [5:0] FUNC_ORR = 6'd3;
  localparam logic [5:0] FUNC_NOT = 6'd4;
  localparam logic [5:0] FUNC_TCP = 6'd5;
  localparam logic [5:0] FUNC_SHL = 6'd6;
  localparam logic [5:0] FUNC_SHR = 6'd7;
  localparam logic [5:0] FUNC_JPR = 6'd25;
  localparam logic [5:0] FUNC_JRL = 6'd26;
  localparam logic [5:0] FUNC_WWD = 6'd28;
  localparam logic [5:0] FUNC_HLT = 6'd29;

  // Control bundle handed to ID/EX
  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic branch;
    logic jump;
    logic halt;
  } id_ctrl_t;

  localparam int ID_CTRL_W = $bits(id_ctrl_t);

  function automatic logic [WORD_SIZE-1:0] sext8(input logic [7:0] v);
    return {{(WORD_SIZE-8){v[7]}}, v};
  endfunction

  function automatic logic [WORD_SIZE-1:0] zext8(input logic [7:0] v);
    return {{(WORD_SIZE-8){1'b0}}, v};
  endfunction

endpackage

// File: rtl/stage_id_if.sv
// stage_id_if
//   ID/EX bundle leaving the decode stage.
//   master: driven by stage_id.   slave: consumed by the EX stage.
//   Handshake: id_valid qualifies every other field in the same cycle. There
//   is no ready; backpressure toward fetch is the separate id_stall signal,
//   and when id_valid=0 the EX stage treats the cycle as a bubble.
interface stage_id_if;
  import stage_id_pkg::*;

  logic                 id_valid;
  logic [WORD_SIZE-1:0] id_pc;
  logic [3:0]           id_opcode;
  logic [5:0]           id_func;
  logic [WORD_SIZE-1:0] id_rs_data;
  logic [WORD_SIZE-1:0] id_rt_data;
  logic [WORD_SIZE-1:0] id_imm;
  logic [REG_IDX_W-1:0] id_dest;
  logic                 id_reg_write;
  logic                 id_mem_read;
  logic                 id_mem_write;
  logic                 id_branch;
  logic                 id_jump;
  logic                 id_halt;

  modport master (
    output id_valid, id_pc, id_opcode, id_func, id_rs_data, id_rt_data,
           id_imm, id_dest, id_reg_write, id_mem_read, id_mem_write,
           id_branch, id_jump, id_halt
  );

  modport slave (
    input  id_valid, id_pc, id_opcode, id_func, id_rs_data, id_rt_data,
           id_imm, id_dest, id_reg_write, id_mem_read, id_mem_write,
           id_branch, id_jump, id_halt
  );
endinterface

// File: rtl/stage_id_register_file.sv
// stage_id_register_file
//   NUM_REGS x WIDTH architectural register file: one write port (from WB),
//   two combinational read ports (rs, rt). Cleared by asynchronous reset.
//   Build option ID_WB_BYPASS_EN: a read of the register being written this
//   cycle returns the write data instead of the old contents.
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   wr_en/wr_idx/wr_data write port, committed on posedge clk
//   rd0_idx/rd0_data     read port 0
//   rd1_idx/rd1_data     read port 1
module stage_id_register_file #(
  parameter int NUM_REGS = 4,
  parameter int WIDTH    = 16,
  parameter int IDX_W    = $clog2(NUM_REGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [IDX_W-1:0] rd0_idx,
  output logic [WIDTH-1:0] rd0_data,
  input  logic [IDX_W-1:0] rd1_idx,
  output logic [WIDTH-1:0] rd1_data
);

  logic [WIDTH-1:0] regs [NUM_REGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en) begin
      regs[wr_idx] <= wr_data;
    end
  end

`ifdef ID_WB_BYPASS_EN
  // Forwarding is gated by rst_n so the read ports stay zero during reset
  // even if WB happens to be asserting a write.
  logic bypass_live;
  assign bypass_live = wr_en & rst_n;
  assign rd0_data = (bypass_live && (wr_idx == rd0_idx)) ? wr_data : regs[rd0_idx];
  assign rd1_data = (bypass_live && (wr_idx == rd1_idx)) ? wr_data : regs[rd1_idx];
`else
  assign rd0_data = regs[rd0_idx];
  assign rd1_data = regs[rd1_idx];
`endif

endmodule

// File: rtl/stage_id.sv
// stage_id
//   TSC decode stage: IF/ID pipeline register, instruction decode, register
//   file read, load-use hazard detection and fetch stall.
//   Build option ID_WB_BYPASS_EN: WB write data is forwarded to the read
//   ports; without it, a read of the register WB is writing this cycle
//   stalls one cycle instead.
// Ports
//   clk, reset_n             clock, asynchronous active-low reset
//   if_instruction, if_pc    instruction and its PC from fetch
//   if_wait                  fetch has no valid instruction this cycle
//   flush                    redirect from EX, kills IF/ID
//   ex_mem_read, ex_dest     LWD in EX and its destination (load-use check)
//   wb_write/wb_dest/wb_data register file write port from WB
//   id_stall                 hold PC and fetch; IF/ID also holds
//   id                       ID/EX bundle (stage_id_if.master)
module stage_id
  import stage_id_pkg::*;
#(
  parameter int                   NUM_REGS = NUM_REGS_DEFAULT,
  parameter logic [REG_IDX_W-1:0] LINK_REG = LINK_REG_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [WORD_SIZE-1:0] if_instruction,
  input  logic [WORD_SIZE-1:0] if_pc,
  input  logic                 if_wait,
  input  logic                 flush,
  input  logic                 ex_mem_read,
  input  logic [REG_IDX_W-1:0] ex_dest,
  input  logic                 wb_write,
  input  logic [REG_IDX_W-1:0] wb_dest,
  input  logic [WORD_SIZE-1:0] wb_data,
  output logic                 id_stall,
  stage_id_if.master           id
);

  // IF/ID pipeline register
  logic                 ifid_valid;
  logic [WORD_SIZE-1:0] ifid_pc;
  logic [WORD_SIZE-1:0] ifid_instr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ifid_valid <= 1'b0;
      ifid_pc    <= '0;
      ifid_instr <= '0;
    end else if (flush) begin
      ifid_valid <= 1'b0;
    end else if (id_stall) begin
      // hold current contents
    end else if (if_wait) begin
      ifid_valid <= 1'b0;
    end else begin
      ifid_valid <= 1'b1;
      ifid_pc    <= if_pc;
      ifid_instr <= if_instruction;
    end
  end

  // Instruction fields
  logic [3:0]           opcode;
  logic [REG_IDX_W-1:0] rs_idx;
  logic [REG_IDX_W-1:0] rt_idx;
  logic [REG_IDX_W-1:0] rd_idx;
  logic [5:0]           func;
  logic [7:0]           imm8;

  assign opcode = ifid_instr[15:12];
  assign rs_idx = ifid_instr[11:10];
  assign rt_idx = ifid_instr[9:8];
  assign rd_idx = ifid_instr[7:6];
  assign func   = ifid_instr[5:0];
  assign imm8   = ifid_instr[7:0];

  // Decode: which sources are really read (drives hazard detection),
  // destination, control bundle and extended immediate.
  logic                 reads_rs;
  logic                 reads_rt;
  logic [REG_IDX_W-1:0] dec_dest;
  id_ctrl_t             dec_ctrl;
  logic [WORD_SIZE-1:0] dec_imm;

  always_comb begin
    reads_rs = 1'b0;
    reads_rt = 1'b0;
    dec_dest = '0;
    dec_ctrl = '0;
    dec_imm  = '0;
    case (opcode)
      OP_BNE, OP_BEQ: begin
        reads_rs        = 1'b1;
        reads_rt        = 1'b1;
        dec_ctrl.branch = 1'b1;
        dec_imm         = sext8(imm8);
      end
      OP_BGZ, OP_BLZ: begin
        reads_rs        = 1'b1;
        dec_ctrl.branch = 1'b1;
        dec_imm         = sext8(imm8);
      end
      OP_ADI: begin
        reads_rs           = 1'b1;
        dec_dest           = rt_idx;
        dec_ctrl.reg_write = 1'b1;
        dec_imm            = sext8(imm8);
      end
      OP_ORI: begin
        reads_rs           = 1'b1;
        dec_dest           = rt_idx;
        dec_ctrl.reg_write = 1'b1;
        dec_imm            = zext8(imm8);
      end
      OP_LHI: begin
        dec_dest           = rt_idx;
        dec_ctrl.reg_write = 1'b1;
        dec_imm            = {imm8, 8'h00};
      end
      OP_LWD: begin
        reads_rs           = 1'b1;
        dec_dest           = rt_idx;
        dec_ctrl.reg_write = 1'b1;
        dec_ctrl.mem_read  = 1'b1;
        dec_imm            = sext8(imm8);
      end
      OP_SWD: begin
        reads_rs           = 1'b1;
        reads_rt           = 1'b1;
        dec_ctrl.mem_write = 1'b1;
        dec_imm            = sext8(imm8);
      end
      OP_JMP: begin
        dec_ctrl.jump = 1'b1;
        dec_imm       = {ifid_pc[15:12], ifid_instr[11:0]};
      end
      OP_JAL: begin
        dec_dest           = LINK_REG;
        dec_ctrl.reg_write = 1'b1;
        dec_ctrl.jump      = 1'b1;
        dec_imm            = {ifid_pc[15:12], ifid_instr[11:0]};
      end
      OP_RTYPE: begin
        case (func)
          FUNC_ADD, FUNC_SUB, FUNC_AND, FUNC_ORR,
          FUNC_NOT, FUNC_TCP, FUNC_SHL, FUNC_SHR: begin
            reads_rs           = 1'b1;
            reads_rt           = 1'b1;
            dec_dest           = rd_idx;
            dec_ctrl.reg_write = 1'b1;
          end
          FUNC_JPR: begin
            reads_rs      = 1'b1;
            dec_ctrl.jump = 1'b1;
          end
          FUNC_JRL: begin
            reads_rs           = 1'b1;
            dec_dest           = LINK_REG;
            dec_ctrl.reg_write = 1'b1;
            dec_ctrl.jump      = 1'b1;
          end
          FUNC_WWD: begin
            reads_rs = 1'b1;
          end
          FUNC_HLT: begin
            dec_ctrl.halt = 1'b1;
          end
          default: begin
            // unknown function: decodes as a NOP
          end
        endcase
      end
      default: begin
        // unknown opcode: decodes as a NOP
      end
    endcase
  end

  // Hazards: only sources the instruction actually reads can stall it.
  logic ex_hit;
  logic load_use;
  logic wb_hazard;

  assign ex_hit   = (reads_rs && (rs_idx == ex_dest)) ||
                    (reads_rt && (rt_idx == ex_dest));
  assign load_use = ifid_valid & ex_mem_read & ex_hit;

`ifdef ID_WB_BYPASS_EN
  assign wb_hazard = 1'b0;
`else
  // Without forwarding, wait one cycle for WB to commit the register.
  logic wb_hit;
  assign wb_hit    = (reads_rs && (rs_idx == wb_dest)) ||
                     (reads_rt && (rt_idx == wb_dest));
  assign wb_hazard = ifid_valid & wb_write & wb_hit;
`endif

  assign id_stall = load_use | wb_hazard;

  // Register file
  logic [WORD_SIZE-1:0] rs_data;
  logic [WORD_SIZE-1:0] rt_data;

  stage_id_register_file #(
    .NUM_REGS (NUM_REGS),
    .WIDTH    (WORD_SIZE),
    .IDX_W    (REG_IDX_W)
  ) u_register_file (
    .clk      (clk),
    .rst_n    (reset_n),
    .wr_en    (wb_write),
    .wr_idx   (wb_dest),
    .wr_data  (wb_data),
    .rd0_idx  (rs_idx),
    .rd0_data (rs_data),
    .rd1_idx  (rt_idx),
    .rd1_data (rt_data)
  );

  // ID/EX outputs; control and destination collapse to zero on a bubble.
  logic                 valid_out;
  logic [ID_CTRL_W-1:0] ctrl_bits;
  id_ctrl_t             ctrl_out;

  assign valid_out = ifid_valid & ~id_stall & ~flush;
  assign ctrl_bits = valid_out ? dec_ctrl : '0;
  assign ctrl_out  = ctrl_bits;

  assign id.id_valid     = valid_out;
  assign id.id_pc        = ifid_pc;
  assign id.id_opcode    = opcode;
  assign id.id_func      = func;
  assign id.id_rs_data   = rs_data;
  assign id.id_rt_data   = rt_data;
  assign id.id_imm       = dec_imm;
  assign id.id_dest      = valid_out ? dec_dest : '0;
  assign id.id_reg_write = ctrl_out.reg_write;
  assign id.id_mem_read  = ctrl_out.mem_read;
  assign id.id_mem_write = ctrl_out.mem_write;
  assign id.id_branch    = ctrl_out.branch;
  assign id.id_jump      = ctrl_out.jump;
  assign id.id_halt      = ctrl_out.halt;

endmodule

// File: tb/tb_stage_id.sv
// tb_stage_id
//   Directed bench for stage_id. Each instruction fed to fetch pushes its
//   hand-derived decode into a scoreboard queue; a negedge monitor pops and
//   compares whenever id_valid is seen. Stall/valid behaviour is checked
//   inline at each directed step. Compile with +define+ID_WB_BYPASS_EN to
//   exercise the bypass build.
module tb_stage_id;

  localparam int W = 82;
  // bundle layout: pc[81:66] op[65:62] func[61:56] imm[55:40] rs[39:24]
  //                rt[23:8] dest[7:6] ctrl[5:0]
  // ctrl = {reg_write, mem_read, mem_write, branch, jump, halt}
  localparam logic [W-1:0] MASK_ALL    = {W{1'b1}};
  localparam logic [W-1:0] MASK_NO_IMM = ~({{(W-16){1'b0}}, 16'hFFFF} << 40);

  // clock / reset
  logic clk;
  logic reset_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // DUT signals
  logic [15:0] if_instruction;
  logic [15:0] if_pc;
  logic        if_wait;
  logic        flush;
  logic        ex_mem_read;
  logic [1:0]  ex_dest;
  logic        wb_write;
  logic [1:0]  wb_dest;
  logic [15:0] wb_data;
  logic        id_stall;

  stage_id_if id_bus ();

  stage_id dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .if_instruction (if_instruction),
    .if_pc          (if_pc),
    .if_wait        (if_wait),
    .flush          (flush),
    .ex_mem_read    (ex_mem_read),
    .ex_dest        (ex_dest),
    .wb_write       (wb_write),
    .wb_dest        (wb_dest),
    .wb_data        (wb_data),
    .id_stall       (id_stall),
    .id             (id_bus)
  );

  logic [W-1:0] obs_bundle;
  assign obs_bundle = {id_bus.id_pc, id_bus.id_opcode, id_bus.id_func,
                       id_bus.id_imm, id_bus.id_rs_data, id_bus.id_rt_data,
                       id_bus.id_dest, id_bus.id_reg_write, id_bus.id_mem_read,
                       id_bus.id_mem_write, id_bus.id_branch, id_bus.id_jump,
                       id_bus.id_halt};

  // scoreboard
  logic [W-1:0] exp_q[$];
  logic [W-1:0] msk_q[$];
  string        tag_q[$];
  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [W-1:0] observed,
                       input logic [W-1:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic push(input string tag, input logic [15:0] pc,
                      input logic [3:0] op, input logic [5:0] fn,
                      input logic [15:0] imm, input logic [15:0] rs,
                      input logic [15:0] rt, input logic [1:0] dest,
                      input logic [5:0] ctrl, input logic [W-1:0] mask);
    exp_q.push_back({pc, op, fn, imm, rs, rt, dest, ctrl});
    msk_q.push_back(mask);
    tag_q.push_back(tag);
  endtask

  // monitor: every valid decode must match the oldest expected entry
  always @(negedge clk) begin
    if (id_bus.id_valid === 1'b1) begin
      check("decode_expected_available", W'(exp_q.size() != 0), W'(1'b1));
      if (exp_q.size() != 0) begin
        logic [W-1:0] e;
        logic [W-1:0] m;
        string t;
        e = exp_q.pop_front();
        m = msk_q.pop_front();
        t = tag_q.pop_front();
        check(t, obs_bundle & m, e & m);
      end
    end
  end

  // driver helpers: inputs change 1 time unit after posedge, outputs are
  // sampled on the following negedge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic feed(input logic [15:0] instr, input logic [15:0] pc);
    if_instruction = instr;
    if_pc          = pc;
    if_wait        = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n        = 1'b0;
    if_instruction = 16'h0000;
    if_pc          = 16'h0000;
    if_wait        = 1'b1;
    flush          = 1'b0;
    ex_mem_read    = 1'b0;
    ex_dest        = 2'd0;
    // WB write attempted during reset must neither show nor land
    wb_write       = 1'b1;
    wb_dest        = 2'd0;
    wb_data        = 16'hFFFF;

    repeat (2) @(posedge clk);
    sample();
    check("reset_bundle", obs_bundle, '0);
    check("reset_valid", W'(id_bus.id_valid), W'(1'b0));
    check("reset_stall", W'(id_stall), W'(1'b0));
    reset_n  = 1'b1;
    wb_write = 1'b0;

    // ADI $1,$0,5 while WB writes $1=0x1111
    tick();
    feed(16'h4105, 16'h0000);
    wb_write = 1'b1; wb_dest = 2'd1; wb_data = 16'h1111;
    push("adi", 16'h0000, 4'h4, 6'h05, 16'h0005, 16'h0000, 16'h1111, 2'd1, 6'b100000, MASK_ALL);
    sample();
    check("empty_ifid_valid", W'(id_bus.id_valid), W'(1'b0));

    tick();
    if_wait = 1'b1;
    wb_write = 1'b1; wb_dest = 2'd2; wb_data = 16'h2222;
    sample();
    check("adi_valid", W'(id_bus.id_valid), W'(1'b1));
    check("adi_stall", W'(id_stall), W'(1'b0));

    // ADD $3,$2,$1 with LWD to $2 in EX
    tick();
    wb_write = 1'b0;
    feed(16'hF9C0, 16'h0002);
    push("add", 16'h0002, 4'hF, 6'h00, 16'h0000, 16'h2222, 16'h1111, 2'd3, 6'b100000, MASK_NO_IMM);

    tick();
    if_wait = 1'b1;
    ex_mem_read = 1'b1; ex_dest = 2'd2;
    sample();
    check("load_use_stall", W'(id_stall), W'(1'b1));
    check("load_use_valid", W'(id_bus.id_valid), W'(1'b0));

    tick();
    ex_mem_read = 1'b0;
    sample();
    check("load_use_release_stall", W'(id_stall), W'(1'b0));
    check("load_use_release_valid", W'(id_bus.id_valid), W'(1'b1));

    // three fetch-wait cycles, then SWD reads $1,$2 to show they held
    for (int i = 0; i < 3; i++) begin
      tick();
      if (i == 2) begin
        feed(16'h8680, 16'h0004);
        push("swd", 16'h0004, 4'h8, 6'h00, 16'hFF80, 16'h1111, 16'h2222, 2'd0, 6'b001000, MASK_ALL);
      end else begin
        if_wait = 1'b1;
      end
      sample();
      check("wait_valid", W'(id_bus.id_valid), W'(1'b0));
      check("wait_stall", W'(id_stall), W'(1'b0));
    end

    // ADI $3,$1,1 hit by flush and load-use together
    tick();
    feed(16'h4701, 16'h0006);
    sample();
    check("swd_valid", W'(id_bus.id_valid), W'(1'b1));

    tick();
    if_wait = 1'b1;
    flush = 1'b1;
    ex_mem_read = 1'b1; ex_dest = 2'd1;
    sample();
    check("flush_valid", W'(id_bus.id_valid), W'(1'b0));

    tick();
    flush = 1'b0;
    sample();
    check("post_flush_stall", W'(id_stall), W'(1'b0));
    check("post_flush_valid", W'(id_bus.id_valid), W'(1'b0));

    // ORI $0,$2,0xF0 while WB writes $2=0xBEEF
    tick();
    ex_mem_read = 1'b0;
    feed(16'h58F0, 16'h0008);
    push("ori_wb", 16'h0008, 4'h5, 6'h30, 16'h00F0, 16'hBEEF, 16'h0000, 2'd0, 6'b100000, MASK_ALL);

    tick();
    if_wait = 1'b1;
    wb_write = 1'b1; wb_dest = 2'd2; wb_data = 16'hBEEF;
    sample();
`ifdef ID_WB_BYPASS_EN
    check("bypass_stall", W'(id_stall), W'(1'b0));
    check("bypass_valid", W'(id_bus.id_valid), W'(1'b1));
    check("bypass_rs_data", W'(id_bus.id_rs_data), W'(16'hBEEF));
`else
    check("wb_hazard_stall", W'(id_stall), W'(1'b1));
    check("wb_hazard_valid", W'(id_bus.id_valid), W'(1'b0));
`endif

    // LHI $1,0x12
    tick();
    wb_write = 1'b0;
    feed(16'h6112, 16'h000A);
    push("lhi", 16'h000A, 4'h6, 6'h12, 16'h1200, 16'h0000, 16'h1111, 2'd1, 6'b100000, MASK_ALL);
    sample();
`ifdef ID_WB_BYPASS_EN
    check("after_bypass_valid", W'(id_bus.id_valid), W'(1'b0));
`else
    check("wb_hazard_release_stall", W'(id_stall), W'(1'b0));
    check("wb_hazard_release_valid", W'(id_bus.id_valid), W'(1'b1));
`endif

    // back-to-back: JAL, BNE, HLT, unknown opcode
    tick();
    feed(16'hA034, 16'h5000);
    push("jal", 16'h5000, 4'hA, 6'h34, 16'h5034, 16'h0000, 16'h0000, 2'd2, 6'b100010, MASK_ALL);

    tick();
    feed(16'h06FE, 16'h5002);
    push("bne", 16'h5002, 4'h0, 6'h3E, 16'hFFFE, 16'h1111, 16'hBEEF, 2'd0, 6'b000100, MASK_ALL);

    tick();
    feed(16'hF01D, 16'h5004);
    push("hlt", 16'h5004, 4'hF, 6'h1D, 16'h0000, 16'h0000, 16'h0000, 2'd0, 6'b000001, MASK_NO_IMM);

    tick();
    feed(16'hB123, 16'h5006);
    push("unknown_nop", 16'h5006, 4'hB, 6'h23, 16'h0000, 16'h0000, 16'h1111, 2'd0, 6'b000000, MASK_NO_IMM);

    tick();
    if_wait = 1'b1;
    repeat (2) tick();
    check("queue_drained", W'(exp_q.size()), W'(0));

    // asynchronous reset between edges with a valid instruction in IF/ID
    feed(16'h4105, 16'h0010);
    @(posedge clk);
    #1;
    if_wait = 1'b1;
    reset_n = 1'b0;
    sample();
    check("async_reset_valid", W'(id_bus.id_valid), W'(1'b0));
    check("async_reset_bundle", obs_bundle, '0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
